// File: rtl/traffic_signal_controller.sv
// traffic_signal_controller
// Five-state Moore controller for a highway / country-road intersection.
// The highway holds green until the country-road sensor x requests service;
// the lights then step through yellow, all-red and country green, and come
// back through country yellow once x clears.
// Optional feature macro: TSC_MIN_GREEN_EN enforces a minimum highway-green
// time of MIN_GREEN cycles before a country request is honoured.

module traffic_signal_controller #(
    parameter int Y2R_DELAY = 3,
    parameter int R2G_DELAY = 2,
    parameter int MIN_GREEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       x,
    output logic [1:0] hwy,
    output logic [1:0] cntry
);

    localparam logic [1:0] LIGHT_RED    = 2'd0;
    localparam logic [1:0] LIGHT_YELLOW = 2'd1;
    localparam logic [1:0] LIGHT_GREEN  = 2'd2;

    // Counter preload values: the timed state exits on the edge where the
    // counter reads zero, so loading DELAY-1 yields exactly DELAY cycles.
    localparam logic [7:0] Y2R_LOAD = 8'(Y2R_DELAY - 1);
    localparam logic [7:0] R2G_LOAD = 8'(R2G_DELAY - 1);

    // Elaboration-time guard on the legal parameter ranges.
    if (Y2R_DELAY < 1 || Y2R_DELAY > 255 || R2G_DELAY < 1 || R2G_DELAY > 255 ||
        MIN_GREEN < 1 || MIN_GREEN > 255) begin : g_bad_params
        $error("traffic_signal_controller: delay parameter out of range 1..255");
    end

    typedef enum logic [2:0] {
        S0 = 3'd0,   // highway green, country red
        S1 = 3'd1,   // highway yellow
        S2 = 3'd2,   // all red
        S3 = 3'd3,   // country green
        S4 = 3'd4    // country yellow
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_cnt;
    logic [7:0] w_next_cnt;
    logic       w_green_ok;

`ifdef TSC_MIN_GREEN_EN
    localparam logic [7:0] MG_THR = 8'(MIN_GREEN - 1);

    logic [7:0] r_green_cnt;

    // Saturating count of cycles spent in S0; cleared whenever S0 is (re)entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_green_cnt <= '0;
        end else if (r_state == S0 && w_next_state == S0) begin
            if (r_green_cnt != 8'hFF) begin
                r_green_cnt <= r_green_cnt + 8'd1;
            end
        end else begin
            r_green_cnt <= '0;
        end
    end

    assign w_green_ok = (r_green_cnt >= MG_THR);
`else
    assign w_green_ok = 1'b1;
`endif

    // State and delay-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S0;
            r_cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking (<=) so every register
            // samples the pre-edge values, independent of statement order.
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch
        // is inferred; unused encodings fall through to S0 with a cleared counter.
        w_next_state = S0;
        w_next_cnt   = '0;
        case (r_state)
            S0: begin
                if (x && w_green_ok) begin
                    w_next_state = S1;
                    w_next_cnt   = Y2R_LOAD;
                end else begin
                    w_next_state = S0;
                end
            end
            S1: begin
                if (r_cnt == 8'd0) begin
                    w_next_state = S2;
                    w_next_cnt   = R2G_LOAD;
                end else begin
                    w_next_state = S1;
                    w_next_cnt   = r_cnt - 8'd1;
                end
            end
            S2: begin
                if (r_cnt == 8'd0) begin
                    w_next_state = S3;
                end else begin
                    w_next_state = S2;
                    w_next_cnt   = r_cnt - 8'd1;
                end
            end
            S3: begin
                if (!x) begin
                    w_next_state = S4;
                    w_next_cnt   = Y2R_LOAD;
                end else begin
                    w_next_state = S3;
                end
            end
            S4: begin
                if (r_cnt == 8'd0) begin
                    w_next_state = S0;
                end else begin
                    w_next_state = S4;
                    w_next_cnt   = r_cnt - 8'd1;
                end
            end
            default: begin
                w_next_state = S0;
            end
        endcase
    end

    // Moore output decode from the state register only.
    always_comb begin
        hwy   = LIGHT_GREEN;
        cntry = LIGHT_RED;
        case (r_state)
            S0: begin
                hwy   = LIGHT_GREEN;
                cntry = LIGHT_RED;
            end
            S1: begin
                hwy   = LIGHT_YELLOW;
                cntry = LIGHT_RED;
            end
            S2: begin
                hwy   = LIGHT_RED;
                cntry = LIGHT_RED;
            end
            S3: begin
                hwy   = LIGHT_RED;
                cntry = LIGHT_GREEN;
            end
            S4: begin
                hwy   = LIGHT_RED;
                cntry = LIGHT_YELLOW;
            end
            default: begin
                hwy   = LIGHT_GREEN;
                cntry = LIGHT_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_signal_controller.sv
// Self-checking bench for traffic_signal_controller (default parameters,
// TSC_MIN_GREEN_EN undefined). Directed vector table, hand-written
// asynchronous-reset sequence, then randomized traffic against a
// schedule-based reference model.

module tb_traffic_signal_controller;

    localparam int Y2R = 3;
    localparam int R2G = 2;

    logic       clk;
    logic       reset;
    logic       x;
    logic [1:0] hwy;
    logic [1:0] cntry;

    int checks;
    int failures;

    traffic_signal_controller #(
        .Y2R_DELAY(Y2R),
        .R2G_DELAY(R2G),
        .MIN_GREEN(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .x    (x),
        .hwy  (hwy),
        .cntry(cntry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] h;
        logic [1:0] c;
    } lights_t;

    localparam lights_t HG = '{h: 2'd2, c: 2'd0};  // highway green
    localparam lights_t HY = '{h: 2'd1, c: 2'd0};  // highway yellow
    localparam lights_t RR = '{h: 2'd0, c: 2'd0};  // all red
    localparam lights_t CG = '{h: 2'd0, c: 2'd2};  // country green
    localparam lights_t CY = '{h: 2'd0, c: 2'd1};  // country yellow

    typedef struct {
        bit         rst_n;
        bit         xin;
        logic [1:0] exp_h;
        logic [1:0] exp_c;
    } vec_t;

    // Reference model: the visible light pattern plus a queue of patterns
    // already committed to by an accepted request (timed phases ignore x).
    lights_t m_cur;
    lights_t m_q[$];

    task automatic model_reset();
        m_cur = HG;
        m_q.delete();
    endtask

    task automatic model_step(input bit xin);
        if (m_q.size() > 0) begin
            m_cur = m_q.pop_front();
        end else if (m_cur == HG && xin) begin
            for (int i = 0; i < Y2R; i++) m_q.push_back(HY);
            for (int i = 0; i < R2G; i++) m_q.push_back(RR);
            m_q.push_back(CG);
            m_cur = m_q.pop_front();
        end else if (m_cur == CG && !xin) begin
            for (int i = 0; i < Y2R; i++) m_q.push_back(CY);
            m_q.push_back(HG);
            m_cur = m_q.pop_front();
        end
    endtask

    task automatic check(input string name, input logic [1:0] exp_h, input logic [1:0] exp_c);
        checks++;
        if (hwy !== exp_h || cntry !== exp_c) begin
            failures++;
            $display("FAIL %s t=%0t: got hwy=%0d cntry=%0d, want hwy=%0d cntry=%0d",
                     name, $time, hwy, cntry, exp_h, exp_c);
        end
    endtask

    // Drive inputs at the falling edge, then sample 1 ns after the rising edge.
    task automatic cycle(input bit r, input bit xv);
        @(negedge clk);
        reset = r;
        x     = xv;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[28];

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        x        = 1'b0;

        // Directed table: reset hold with x toggling, full cycle, x held
        // through S4, then single-cycle pulse giving a one-cycle S3.
        vecs[0]  = '{0, 1, 2'd2, 2'd0};
        vecs[1]  = '{0, 0, 2'd2, 2'd0};
        vecs[2]  = '{0, 1, 2'd2, 2'd0};
        vecs[3]  = '{1, 0, 2'd2, 2'd0};
        vecs[4]  = '{1, 0, 2'd2, 2'd0};
        vecs[5]  = '{1, 1, 2'd1, 2'd0};  // edge k
        vecs[6]  = '{1, 0, 2'd1, 2'd0};
        vecs[7]  = '{1, 1, 2'd1, 2'd0};
        vecs[8]  = '{1, 0, 2'd0, 2'd0};
        vecs[9]  = '{1, 1, 2'd0, 2'd0};
        vecs[10] = '{1, 1, 2'd0, 2'd2};  // k+5
        vecs[11] = '{1, 1, 2'd0, 2'd2};
        vecs[12] = '{1, 1, 2'd0, 2'd2};
        vecs[13] = '{1, 0, 2'd0, 2'd1};  // edge m
        vecs[14] = '{1, 1, 2'd0, 2'd1};
        vecs[15] = '{1, 1, 2'd0, 2'd1};
        vecs[16] = '{1, 1, 2'd2, 2'd0};  // m+3, x still held
        vecs[17] = '{1, 1, 2'd1, 2'd0};  // re-enter S1 next edge
        vecs[18] = '{1, 0, 2'd1, 2'd0};
        vecs[19] = '{1, 0, 2'd1, 2'd0};
        vecs[20] = '{1, 0, 2'd0, 2'd0};
        vecs[21] = '{1, 0, 2'd0, 2'd0};
        vecs[22] = '{1, 0, 2'd0, 2'd2};  // S3 entered with x=0
        vecs[23] = '{1, 0, 2'd0, 2'd1};  // S3 lasted one cycle
        vecs[24] = '{1, 0, 2'd0, 2'd1};
        vecs[25] = '{1, 0, 2'd0, 2'd1};
        vecs[26] = '{1, 0, 2'd2, 2'd0};
        vecs[27] = '{1, 0, 2'd2, 2'd0};

        for (int i = 0; i < 28; i++) begin
            cycle(vecs[i].rst_n, vecs[i].xin);
            check($sformatf("vec%0d", i), vecs[i].exp_h, vecs[i].exp_c);
        end

        // Idle: 20 cycles with no request keeps the highway green.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0);
            check($sformatf("idle%0d", i), 2'd2, 2'd0);
        end

        // Async reset mid-S3: outputs must snap to (2,0) without a clock edge.
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1);
        check("pre_async_s3", 2'd0, 2'd2);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_immediate", 2'd2, 2'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, i[0]);
            check($sformatf("reset_hold%0d", i), 2'd2, 2'd0);
        end
        // First edge after release samples x=1 and goes straight to yellow.
        cycle(1'b1, 1'b1);
        check("post_reset_first_edge", 2'd1, 2'd0);

        // Randomized traffic with occasional resets against the model.
        cycle(1'b0, 1'b0);
        model_reset();
        check("rand_reset", HG.h, HG.c);
        begin
            bit xv;
            int run;
            xv  = 1'b0;
            run = 0;
            for (int i = 0; i < 3000; i++) begin
                if (run == 0) begin
                    xv  = ~xv;
                    run = $urandom_range(1, 9);
                end
                run--;
                if ($urandom_range(0, 299) == 0) begin
                    cycle(1'b0, xv);
                    model_reset();
                end else begin
                    cycle(1'b1, xv);
                    model_step(xv);
                end
                check($sformatf("rand%0d", i), m_cur.h, m_cur.c);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
